// File: rtl/preg_free_list_pkg.sv
// -----------------------------------------------------------------------------
// preg_free_list_pkg
//   Shared sizing constants and types for the physical-register free list.
//   NUM_PREGS physical registers; the first NUM_AREGS hold the reset
//   architectural mapping (areg i -> preg i). The remaining FL_DEPTH registers
//   start out on the free list.
// -----------------------------------------------------------------------------
package preg_free_list_pkg;

  localparam int NUM_PREGS    = 64;
  localparam int NUM_AREGS    = 32;
  localparam int PREG_BITS    = $clog2(NUM_PREGS);

  // Pipeline widths of the neighbouring stages.
  localparam int DISP_WIDTH   = 2;
  localparam int RETIRE_WIDTH = 2;

  // Free-list geometry.
  localparam int FL_DEPTH     = NUM_PREGS - NUM_AREGS;
  localparam int PTR_BITS     = $clog2(FL_DEPTH);
  localparam int CNT_BITS     = $clog2(FL_DEPTH + 1);

  typedef logic [PREG_BITS-1:0] preg_t;

  // Contents of free-list entry k straight out of reset.
  function automatic preg_t reset_preg(input int k);
    return preg_t'(NUM_AREGS + k);
  endfunction

endpackage

// File: rtl/preg_free_list_prefix_compactor.sv
// -----------------------------------------------------------------------------
// preg_free_list_prefix_compactor
//   Maps a sparse valid vector onto dense write offsets: the k-th set bit (in
//   slot order) receives offset k. Also reports the number of set bits.
//   Purely combinational; usable wherever sparse slots must be packed into
//   consecutive storage entries.
//
// Ports:
//   valid   in  [W]            per-slot valid strobes, any pattern
//   offset  out [W][OFF_BITS]  dense position of each slot (don't-care when
//                              that slot is not valid)
//   n_valid out [OFF_BITS]     popcount(valid)
// -----------------------------------------------------------------------------
module preg_free_list_prefix_compactor #(
  parameter int W = 2,
  localparam int OFF_BITS = $clog2(W + 1)
) (
  input  logic [W-1:0]               valid,
  output logic [W-1:0][OFF_BITS-1:0] offset,
  output logic [OFF_BITS-1:0]        n_valid
);

  logic [OFF_BITS-1:0] acc_s;

  // Running prefix count: each slot's offset is the number of valid slots below it.
  always_comb begin
    acc_s  = '0;
    offset = '0;
    for (int i = 0; i < W; i++) begin
      offset[i] = acc_s;
      if (valid[i]) begin
        acc_s = acc_s + OFF_BITS'(1);
      end else begin
        acc_s = acc_s;
      end
    end
    n_valid = acc_s;
  end

endmodule

// File: rtl/preg_free_list.sv
// -----------------------------------------------------------------------------
// preg_free_list
//   Circular free list of unmapped physical registers for the rename stage.
//   Rename takes up to ALLOC_WIDTH fresh pregs per cycle from the head; ROB
//   retirement returns up to FREE_WIDTH pregs per cycle at the tail.
//
//   Allocation is all-or-nothing: alloc_ok is high only when the current count
//   covers every requested slot, and then all of them commit this cycle.
//   There is no bypass from free to alloc: a preg freed this cycle becomes
//   visible on alloc_preg the following cycle. Releases of p0 are dropped,
//   since x0 permanently owns p0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   alloc_req     [ALLOC_WIDTH]            prefix-packed allocation requests
//   alloc_ok      out                      request fits; allocation commits
//   alloc_preg    [ALLOC_WIDTH] x preg_t   slot i = list[head+i]
//   free_valid    [FREE_WIDTH]             release strobes, any pattern
//   free_preg     [FREE_WIDTH] x preg_t    pregs released by retirement
//   free_count    [CNT_BITS]               entries currently on the list
//   empty         out                      free_count == 0
//   fl_error      out (FREELIST_CHECK_EN)  sticky protocol-error flag
//
// Build option:
//   FREELIST_CHECK_EN  adds an is_free shadow vector and the fl_error output,
//                      flagging double frees, frees of p0, duplicate frees in
//                      one cycle, non-prefix-packed requests and count
//                      overflow.
// -----------------------------------------------------------------------------
module preg_free_list
  import preg_free_list_pkg::*;
#(
  parameter int ALLOC_WIDTH = DISP_WIDTH,
  parameter int FREE_WIDTH  = RETIRE_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ALLOC_WIDTH-1:0]        alloc_req,
  output logic                          alloc_ok,
  output preg_t [ALLOC_WIDTH-1:0]       alloc_preg,
  input  logic [FREE_WIDTH-1:0]         free_valid,
  input  preg_t [FREE_WIDTH-1:0]        free_preg,
  output logic [CNT_BITS-1:0]           free_count,
  output logic                          empty
`ifdef FREELIST_CHECK_EN
  ,
  output logic                          fl_error
`endif
);

  localparam int AW_BITS = $clog2(ALLOC_WIDTH + 1);
  localparam int FW_BITS = $clog2(FREE_WIDTH + 1);
  localparam int CW1     = CNT_BITS + 1;

  // Storage and pointers.
  preg_t               list_r [FL_DEPTH];
  logic [PTR_BITS-1:0] head_r;
  logic [PTR_BITS-1:0] tail_r;
  logic [CNT_BITS-1:0] count_r;

  // Allocation side.
  logic [AW_BITS-1:0]  n_req_s;
  logic [AW_BITS-1:0]  n_alloc_s;
  logic                alloc_ok_s;

  // Release side.
  logic [FREE_WIDTH-1:0]              free_eff_s;
  logic [FREE_WIDTH-1:0][FW_BITS-1:0] wr_off_s;
  logic [FW_BITS-1:0]                 n_free_s;

  // Count update.
  logic [CW1-1:0]      count_sum_s;
  logic [CNT_BITS-1:0] count_next_s;
  logic                overflow_s;

  // Popcount of the request vector.
  always_comb begin
    n_req_s = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      if (alloc_req[i]) begin
        n_req_s = n_req_s + AW_BITS'(1);
      end else begin
        n_req_s = n_req_s;
      end
    end
  end

  // Grant decision from the pre-cycle count; all requested slots or none.
  always_comb begin
    alloc_ok_s = ({1'b0, count_r} >= CW1'(n_req_s));
    if (alloc_ok_s) begin
      n_alloc_s = n_req_s;
    end else begin
      n_alloc_s = '0;
    end
  end

  // Head-relative read ports; the pointer add wraps naturally at FL_DEPTH.
  always_comb begin
    alloc_preg = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_preg[i] = list_r[head_r + PTR_BITS'(i)];
    end
  end

  // Releases of p0 are dropped before compaction.
  always_comb begin
    free_eff_s = '0;
    for (int i = 0; i < FREE_WIDTH; i++) begin
      free_eff_s[i] = free_valid[i] && (free_preg[i] != '0);
    end
  end

  preg_free_list_prefix_compactor #(
    .W       (FREE_WIDTH)
  ) u_free_compactor (
    .valid   (free_eff_s),
    .offset  (wr_off_s),
    .n_valid (n_free_s)
  );

  // Next count at one extra bit; an overflow (double free into a full list)
  // saturates at FL_DEPTH. Underflow cannot happen since grants are gated.
  always_comb begin
    count_sum_s = {1'b0, count_r} + CW1'(n_free_s) - CW1'(n_alloc_s);
    overflow_s  = (count_sum_s > CW1'(FL_DEPTH));
    if (overflow_s) begin
      count_next_s = CNT_BITS'(FL_DEPTH);
    end else begin
      count_next_s = count_sum_s[CNT_BITS-1:0];
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= CNT_BITS'(FL_DEPTH);
    end else begin
      head_r  <= head_r + PTR_BITS'(n_alloc_s);
      tail_r  <= tail_r + PTR_BITS'(n_free_s);
      count_r <= count_next_s;
    end
  end

  // List storage: reset image NUM_AREGS+k, compacted writes at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        list_r[k] <= reset_preg(k);
      end
    end else begin
      for (int i = 0; i < FREE_WIDTH; i++) begin
        if (free_eff_s[i]) begin
          list_r[tail_r + PTR_BITS'(wr_off_s[i])] <= free_preg[i];
        end
      end
    end
  end

  assign alloc_ok   = alloc_ok_s;
  assign free_count = count_r;
  assign empty      = (count_r == '0);

`ifdef FREELIST_CHECK_EN
  logic [NUM_PREGS-1:0] is_free_r;
  logic [NUM_PREGS-1:0] is_free_next_s;
  logic                 err_event_s;
  logic                 fl_error_r;

  // Protocol violations observed this cycle.
  always_comb begin
    err_event_s = overflow_s;
    for (int i = 1; i < ALLOC_WIDTH; i++) begin
      err_event_s = err_event_s | (alloc_req[i] & ~alloc_req[i-1]);
    end
    for (int i = 0; i < FREE_WIDTH; i++) begin
      err_event_s = err_event_s | (free_valid[i] & (free_preg[i] == '0));
      err_event_s = err_event_s | (free_eff_s[i] & is_free_r[free_preg[i]]);
      for (int j = i + 1; j < FREE_WIDTH; j++) begin
        err_event_s = err_event_s |
                      (free_eff_s[i] & free_eff_s[j] & (free_preg[i] == free_preg[j]));
      end
    end
  end

  // Shadow update: granted slots clear their bit first, releases then set.
  always_comb begin
    is_free_next_s = is_free_r;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      is_free_next_s[alloc_preg[i]] = is_free_next_s[alloc_preg[i]] &
                                      ~(i < int'(n_alloc_s));
    end
    for (int i = 0; i < FREE_WIDTH; i++) begin
      is_free_next_s[free_preg[i]] = is_free_next_s[free_preg[i]] | free_eff_s[i];
    end
  end

  // Shadow vector and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_free_r  <= {{FL_DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
      fl_error_r <= 1'b0;
    end else begin
      is_free_r  <= is_free_next_s;
      fl_error_r <= fl_error_r | err_event_s;
    end
  end

  assign fl_error = fl_error_r;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  logic             clk;
  logic             rst;
  logic [1:0]       alloc_req;
  logic             alloc_ok;
  logic [1:0][5:0]  alloc_preg;
  logic [1:0]       free_valid;
  logic [1:0][5:0]  free_preg;
  logic [5:0]       free_count;
  logic             empty;
`ifdef FREELIST_CHECK_EN
  logic             fl_error;
`endif

  int assert_cnt = 0;
  int fail_cnt   = 0;

  preg_free_list dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_ok   (alloc_ok),
    .alloc_preg (alloc_preg),
    .free_valid (free_valid),
    .free_preg  (free_preg),
    .free_count (free_count),
    .empty      (empty)
`ifdef FREELIST_CHECK_EN
    ,
    .fl_error   (fl_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_req = 2'b00;
    free_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    // Reset must override simultaneous alloc/free activity.
    rst = 1'b1;
    alloc_req = 2'b11;
    free_valid = 2'b11;
    free_preg[0] = 6'd8;
    free_preg[1] = 6'd9;
    tick();
    tick();
    rst = 1'b0;
    alloc_req = 2'b00;
    free_valid = 2'b00;
    #1;
    assert_cnt++;
    if (free_count !== 6'd32) begin
      fail_cnt++; $display("FAIL reset_count: got %0d expected 32", free_count);
    end
    assert_cnt++;
    if (empty !== 1'b0) begin
      fail_cnt++; $display("FAIL reset_empty: got %b expected 0", empty);
    end
    assert_cnt++;
    if (alloc_preg[0] !== 6'd32 || alloc_preg[1] !== 6'd33) begin
      fail_cnt++; $display("FAIL reset_preg: got (%0d,%0d) expected (32,33)", alloc_preg[0], alloc_preg[1]);
    end
    assert_cnt++;
    if (alloc_ok !== 1'b1) begin
      fail_cnt++; $display("FAIL reset_ok_req0: got %b expected 1", alloc_ok);
    end
    alloc_req = 2'b01;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b1) begin
      fail_cnt++; $display("FAIL reset_ok_req1: got %b expected 1", alloc_ok);
    end
    alloc_req = 2'b11;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b1) begin
      fail_cnt++; $display("FAIL reset_ok_req2: got %b expected 1", alloc_ok);
    end
    alloc_req = 2'b00;
`ifdef FREELIST_CHECK_EN
    assert_cnt++;
    if (fl_error !== 1'b0) begin
      fail_cnt++; $display("FAIL reset_fl_error: got %b expected 0", fl_error);
    end
`endif
  endtask

  task automatic test_drain();
    for (int c = 0; c < 16; c++) begin
      alloc_req = 2'b11;
      #1;
      assert_cnt++;
      if (alloc_ok !== 1'b1) begin
        fail_cnt++; $display("FAIL drain_ok c=%0d: got %b expected 1", c, alloc_ok);
      end
      assert_cnt++;
      if (alloc_preg[0] !== 6'(32 + 2 * c) || alloc_preg[1] !== 6'(33 + 2 * c)) begin
        fail_cnt++; $display("FAIL drain_preg c=%0d: got (%0d,%0d) expected (%0d,%0d)",
                             c, alloc_preg[0], alloc_preg[1], 32 + 2 * c, 33 + 2 * c);
      end
      tick();
      assert_cnt++;
      if (free_count !== 6'(32 - 2 * (c + 1))) begin
        fail_cnt++; $display("FAIL drain_count c=%0d: got %0d expected %0d", c, free_count, 32 - 2 * (c + 1));
      end
    end
    alloc_req = 2'b00;
    #1;
    assert_cnt++;
    if (empty !== 1'b1) begin
      fail_cnt++; $display("FAIL drain_empty: got %b expected 1", empty);
    end
    alloc_req = 2'b11;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b0) begin
      fail_cnt++; $display("FAIL drain_ok17_req2: got %b expected 0", alloc_ok);
    end
    alloc_req = 2'b01;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b0) begin
      fail_cnt++; $display("FAIL drain_ok17_req1: got %b expected 0", alloc_ok);
    end
    alloc_req = 2'b00;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b1) begin
      fail_cnt++; $display("FAIL empty_req0_ok: got %b expected 1", alloc_ok);
    end
    tick();
    assert_cnt++;
    if (free_count !== 6'd0) begin
      fail_cnt++; $display("FAIL empty_req0_count: got %0d expected 0", free_count);
    end
  endtask

  task automatic test_free_into_empty();
    alloc_req = 2'b11;
    free_valid = 2'b11;
    free_preg[0] = 6'd40;
    free_preg[1] = 6'd7;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b0) begin
      fail_cnt++; $display("FAIL nobypass_ok: got %b expected 0", alloc_ok);
    end
    tick();
    alloc_req = 2'b00;
    free_valid = 2'b00;
    #1;
    assert_cnt++;
    if (free_count !== 6'd2) begin
      fail_cnt++; $display("FAIL refill_count: got %0d expected 2", free_count);
    end
    assert_cnt++;
    if (alloc_preg[0] !== 6'd40 || alloc_preg[1] !== 6'd7) begin
      fail_cnt++; $display("FAIL refill_preg: got (%0d,%0d) expected (40,7)", alloc_preg[0], alloc_preg[1]);
    end
  endtask

  task automatic test_partial_alloc();
    alloc_req = 2'b01;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b1 || alloc_preg[0] !== 6'd40) begin
      fail_cnt++; $display("FAIL partial_first: got ok=%b p=%0d expected ok=1 p=40", alloc_ok, alloc_preg[0]);
    end
    tick();
    assert_cnt++;
    if (free_count !== 6'd1) begin
      fail_cnt++; $display("FAIL partial_count1: got %0d expected 1", free_count);
    end
    alloc_req = 2'b11;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b0) begin
      fail_cnt++; $display("FAIL partial_deny_ok: got %b expected 0", alloc_ok);
    end
    tick();
    alloc_req = 2'b00;
    #1;
    assert_cnt++;
    if (free_count !== 6'd1 || alloc_preg[0] !== 6'd7) begin
      fail_cnt++; $display("FAIL partial_deny_state: got count=%0d p=%0d expected count=1 p=7", free_count, alloc_preg[0]);
    end
    alloc_req = 2'b01;
    #1;
    assert_cnt++;
    if (alloc_ok !== 1'b1) begin
      fail_cnt++; $display("FAIL partial_single_ok: got %b expected 1", alloc_ok);
    end
    tick();
    alloc_req = 2'b00;
    #1;
    assert_cnt++;
    if (free_count !== 6'd0 || empty !== 1'b1) begin
      fail_cnt++; $display("FAIL partial_single_count: got count=%0d empty=%b expected 0/1", free_count, empty);
    end
  endtask

  task automatic test_free_slots();
    // Only slot 1 valid: lands at list[tail].
    free_valid = 2'b10;
    free_preg[0] = 6'd9;
    free_preg[1] = 6'd50;
    tick();
    free_valid = 2'b00;
    #1;
    assert_cnt++;
    if (free_count !== 6'd1 || alloc_preg[0] !== 6'd50) begin
      fail_cnt++; $display("FAIL slot1_free: got count=%0d p=%0d expected count=1 p=50", free_count, alloc_preg[0]);
    end
    // A release of p0 is ignored.
    free_valid = 2'b01;
    free_preg[0] = 6'd0;
    tick();
    free_valid = 2'b00;
    #1;
    assert_cnt++;
    if (free_count !== 6'd1 || alloc_preg[0] !== 6'd50) begin
      fail_cnt++; $display("FAIL p0_free: got count=%0d p=%0d expected count=1 p=50", free_count, alloc_preg[0]);
    end
    // p0 in slot 0 dropped, slot 1 compacted down to the tail.
    free_valid = 2'b11;
    free_preg[0] = 6'd0;
    free_preg[1] = 6'd51;
    tick();
    free_valid = 2'b00;
    #1;
    assert_cnt++;
    if (free_count !== 6'd2 || alloc_preg[0] !== 6'd50 || alloc_preg[1] !== 6'd51) begin
      fail_cnt++; $display("FAIL p0_compact: got count=%0d p=(%0d,%0d) expected count=2 p=(50,51)",
                           free_count, alloc_preg[0], alloc_preg[1]);
    end
  endtask

  task automatic test_steady_state();
    logic [5:0] exp_q[$];
    logic [5:0] prev0;
    logic [5:0] prev1;
    logic [5:0] e0;
    logic [5:0] e1;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back(6'(32 + k));
    end
    prev0 = 6'd1;
    prev1 = 6'd2;
    for (int c = 0; c < 100; c++) begin
      alloc_req = 2'b11;
      free_valid = 2'b11;
      free_preg[0] = prev0;
      free_preg[1] = prev1;
      #1;
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      exp_q.push_back(prev0);
      exp_q.push_back(prev1);
      assert_cnt++;
      if (alloc_ok !== 1'b1 || alloc_preg[0] !== e0 || alloc_preg[1] !== e1) begin
        fail_cnt++; $display("FAIL steady_alloc c=%0d: got ok=%b p=(%0d,%0d) expected ok=1 p=(%0d,%0d)",
                             c, alloc_ok, alloc_preg[0], alloc_preg[1], e0, e1);
      end
      tick();
      assert_cnt++;
      if (free_count !== 6'd32) begin
        fail_cnt++; $display("FAIL steady_count c=%0d: got %0d expected 32", c, free_count);
      end
      prev0 = e0;
      prev1 = e1;
    end
    alloc_req = 2'b00;
    free_valid = 2'b00;
  endtask

`ifdef FREELIST_CHECK_EN
  task automatic test_check_double_free();
    do_reset();
    // Allocate 32..45 so that p45 is in flight.
    for (int c = 0; c < 7; c++) begin
      alloc_req = 2'b11;
      tick();
    end
    alloc_req = 2'b00;
    free_valid = 2'b01;
    free_preg[0] = 6'd45;
    tick();
    free_valid = 2'b00;
    #1;
    assert_cnt++;
    if (fl_error !== 1'b0 || free_count !== 6'd19) begin
      fail_cnt++; $display("FAIL chk_legal_free: got err=%b count=%0d expected err=0 count=19", fl_error, free_count);
    end
    free_valid = 2'b01;
    free_preg[0] = 6'd45;
    tick();
    free_valid = 2'b00;
    #1;
    assert_cnt++;
    if (fl_error !== 1'b1) begin
      fail_cnt++; $display("FAIL chk_double_free: got %b expected 1", fl_error);
    end
    tick();
    tick();
    assert_cnt++;
    if (fl_error !== 1'b1) begin
      fail_cnt++; $display("FAIL chk_sticky: got %b expected 1", fl_error);
    end
    do_reset();
    assert_cnt++;
    if (fl_error !== 1'b0) begin
      fail_cnt++; $display("FAIL chk_clear: got %b expected 0", fl_error);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    alloc_req = 2'b00;
    free_valid = 2'b00;
    free_preg = '0;
    test_reset();
    test_drain();
    test_free_into_empty();
    test_partial_alloc();
    test_free_slots();
    test_steady_state();
`ifdef FREELIST_CHECK_EN
    test_check_double_free();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
